clock_enable_manager: RTL

//  Synthesizable clock/reset manager for the AES datapath and its peripherals.

---
 rtl/clock_enable_manager.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/clock_enable_manager.sv
// clock_enable_manager
//   Clock/reset manager for the AES datapath. Produces a synchronised, stretched
//   core reset and NUM_CH independent programmable clock-enable channels.
//
// Ports
//   clock      in   system clock, all logic on the rising edge
//   reset      in   asynchronous active-high master reset
//   soft_rst   in   synchronous request to re-run the hold sequence (HOLD/RUN only)
//   ch_en      in   per-channel run enable
//   div_load   in   per-channel one-cycle divisor load strobe
//   div_value  in   divisor bus, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   rst_out    out  core reset: asserts asynchronously, deasserts on a clock edge
//   tick       out  one-cycle enable in the last cycle of each period
//   div_clk    out  registered near-50% divided level
//   div_busy   out  a loaded divisor is waiting for the period boundary
module clock_enable_manager #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DIV_WIDTH   = 16,
   parameter int unsigned RST_HOLD    = 8,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          soft_rst,
   input  logic [NUM_CH-1:0]             ch_en,
   input  logic [NUM_CH-1:0]             div_load,
   input  logic [NUM_CH*DIV_WIDTH-1:0]   div_value,
   output logic                          rst_out,
   output logic [NUM_CH-1:0]             tick,
   output logic [NUM_CH-1:0]             div_clk,
   output logic [NUM_CH-1:0]             div_busy
);

   localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);
   localparam logic [DIV_WIDTH-1:0] DefDiv = DIV_WIDTH'(DEFAULT_DIV);

   typedef enum logic [1:0] {StAssert, StSync, StHold, StRun} rst_state_e;

   rst_state_e       state_q, state_d;
   logic [1:0]       sync_q, sync_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             rst_out_q, rst_out_d;

   // ---------------------------------------------------------------------------
   // Reset sequencer
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      // The synchroniser flops are preset by reset and shift in the released level.
      sync_d  = {sync_q[0], 1'b0};
      unique case (state_q)
         StAssert: state_d = StSync;
         StSync: begin
            if (!sync_q[1]) begin
               state_d = StHold;
               hold_d  = '0;
            end
         end
         StHold: begin
            if (soft_rst) begin
               hold_d = '0;
            end else if (hold_q == HoldLast) begin
               state_d = StRun;
            end else begin
               hold_d = hold_q + HoldW'(1);
            end
         end
         StRun: begin
            if (soft_rst) begin
               state_d = StHold;
               hold_d  = '0;
            end
         end
         default: state_d = StAssert;
      endcase
      // Registered from the next state so rst_out is glitch-free.
      rst_out_d = (state_d != StRun);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StAssert;
         sync_q    <= 2'b11;
         hold_q    <= '0;
         rst_out_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         hold_q    <= hold_d;
         rst_out_q <= rst_out_d;
      end
   end

   assign rst_out = rst_out_q;

   // ---------------------------------------------------------------------------
   // Divider channels
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
      logic [DIV_WIDTH-1:0] act_q, act_d;
      logic [DIV_WIDTH-1:0] pend_q, pend_d;
      logic                 busy_q, busy_d;
      logic                 dclk_q, dclk_d;
      logic [DIV_WIDTH-1:0] load_val, period, half;
      logic                 run, last;

      assign load_val = div_value[i*DIV_WIDTH +: DIV_WIDTH];

      always_comb begin
         // A zero divisor behaves as a period of one.
         period = (act_q == '0) ? DIV_WIDTH'(1) : act_q;
         half   = {1'b0, period[DIV_WIDTH-1:1]} + {{(DIV_WIDTH-1){1'b0}}, period[0]};
         run    = ch_en[i] && !rst_out_q;
         last   = (cnt_q == period - DIV_WIDTH'(1));

         cnt_d  = cnt_q;
         act_d  = act_q;
         pend_d = pend_q;
         busy_d = busy_q;
         dclk_d = run && (cnt_q < half);

         if (!run || last) begin
            // Period boundary (or idle): apply the newest divisor, a same-cycle
            // load bypassing the pending register.
            cnt_d  = '0;
            act_d  = div_load[i] ? load_val : pend_q;
            pend_d = act_d;
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
            if (div_load[i]) begin
               pend_d = load_val;
               busy_d = 1'b1;
            end
         end
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            cnt_q  <= '0;
            act_q  <= DefDiv;
            pend_q <= DefDiv;
            busy_q <= 1'b0;
            dclk_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            dclk_q <= dclk_d;
         end
      end

      assign tick[i]     = run && last;
      assign div_clk[i]  = dclk_q;
      assign div_busy[i] = busy_q;
   end

endmodule
